score_digits_renderer: RTL and testbench

- Parametrised successor to the two-digit score overlay. Renders an unsigned score as NUM_DIGITS decimal seven-segment glyphs at a configurable screen position.
- Converts binary to BCD with a sequential double-dabble engine. The score is sampled once per frame on frame_start, so the displayed value never tears mid-frame.
- Pixel path is a fixed 2-stage pipeline. Its output feeds the VGA colour mux alongside the other sprite/overlay masks.

---
 rtl/score_disp_pkg.sv | 56 +++++
 rtl/score_digits_renderer_bin2bcd.sv | 79 +++++++
 rtl/score_digits_renderer.sv | 145 ++++++++++++++
 tb/tb_score_digits_renderer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - glyph geometry, segment decode and BCD sizing for the score renderer
`timescale 1ns/1ps
package score_disp_pkg;

    // Digit cell footprint in pixels.
    localparam logic [3:0] CELL_W = 4'd13;
    localparam logic [3:0] CELL_H = 4'd15;

    // Horizontal bars: a on top, g in the middle, d at the bottom.
    localparam logic [3:0] SEG_A_Y1 = 4'd3;
    localparam logic [3:0] SEG_G_Y0 = 4'd6;
    localparam logic [3:0] SEG_G_Y1 = 4'd8;
    localparam logic [3:0] SEG_D_Y0 = 4'd11;

    // Vertical bars: upper pair (f, b) ends at row 8, lower pair (e, c) starts at row 6.
    localparam logic [3:0] SEG_UP_Y1 = 4'd8;
    localparam logic [3:0] SEG_LO_Y0 = 4'd6;
    localparam logic [3:0] SEG_L_X1  = 4'd2;
    localparam logic [3:0] SEG_R_X0  = 4'd10;

    // Segment mask {a,b,c,d,e,f,g} for a decimal digit; non-decimal codes draw nothing.
    function automatic logic [6:0] seg_of_digit(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b111_1110;
            4'd1:    return 7'b011_0000;
            4'd2:    return 7'b110_1101;
            4'd3:    return 7'b111_1001;
            4'd4:    return 7'b011_0011;
            4'd5:    return 7'b101_1011;
            4'd6:    return 7'b101_1111;
            4'd7:    return 7'b111_0000;
            4'd8:    return 7'b111_1111;
            4'd9:    return 7'b111_1011;
            default: return 7'b000_0000;
        endcase
    endfunction

    // Which segments {a,b,c,d,e,f,g} cover a cell-relative pixel (caller guarantees it is inside the cell).
    function automatic logic [6:0] seg_at(input logic [3:0] cx, input logic [3:0] cy);
        logic sa, sb, sc, sd, se, sf, sg;
        sa = (cy <= SEG_A_Y1);
        sg = (cy >= SEG_G_Y0) && (cy <= SEG_G_Y1);
        sd = (cy >= SEG_D_Y0);
        sf = (cy <= SEG_UP_Y1) && (cx <= SEG_L_X1);
        sb = (cy <= SEG_UP_Y1) && (cx >= SEG_R_X0);
        se = (cy >= SEG_LO_Y0) && (cx <= SEG_L_X1);
        sc = (cy >= SEG_LO_Y0) && (cx >= SEG_R_X0);
        return {sa, sb, sc, sd, se, sf, sg};
    endfunction

    // Decimal digits needed to hold any width-bit value: ceil(width*log10(2)) + 1.
    function automatic int bcd_digits(input int width);
        return (width * 30103 + 99999) / 100000 + 1;
    endfunction

endpackage

// File: rtl/score_digits_renderer_bin2bcd.sv
// rtl/score_digits_renderer_bin2bcd.sv - sequential double-dabble binary to BCD converter
`timescale 1ns/1ps
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int BIN_W = 8,
    parameter int BCD_D = bcd_digits(BIN_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin,
    output logic                 busy,
    output logic                 done,
    output logic [4*BCD_D-1:0]   bcd
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam int             CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

    logic [1:0]          state;
    logic [BIN_W-1:0]    shreg;
    logic [4*BCD_D-1:0]  acc;
    logic [4*BCD_D-1:0]  acc_adj;
    logic [CNT_W-1:0]    cnt;

    // Add-3 correction on every nibble that would overflow past 9 after the next shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < BCD_D; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // IDLE -> SHIFT (BIN_W cycles) -> COMMIT (1 cycle) -> IDLE; start is ignored outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        shreg <= bin;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {acc, shreg} <= {acc_adj, shreg} << 1;
                    cnt          <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_COMMIT);
    assign bcd  = acc;

endmodule

// File: rtl/score_digits_renderer.sv
// rtl/score_digits_renderer.sv - frame-latched score rendered as seven-segment digit cells
`timescale 1ns/1ps
module score_digits_renderer
    import score_disp_pkg::*;
#(
    parameter int SCORE_W     = 8,
    parameter int NUM_DIGITS  = 3,
    parameter int X0          = 10,
    parameter int Y0          = 15,
    parameter int DIGIT_PITCH = 20,
    parameter int BLANK_LZ    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               frame_start,
    input  logic [9:0]         H_Coord,
    input  logic [9:0]         V_Coord,
    output logic               points_display,
    output logic               busy,
    output logic               overflow
);

    localparam int BCD_D = bcd_digits(SCORE_W);
    // At least one nibble above the displayed digits so the overflow test is never empty.
    localparam int EXT_D = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS + 1;

    logic                    conv_done;
    logic [4*BCD_D-1:0]      conv_bcd;
    logic [4*EXT_D-1:0]      bcd_ext;
    logic                    conv_over;
    logic [4*NUM_DIGITS-1:0] disp;
    logic [3:0]              dig_arr [8];
    logic [7:0]              lz;

    bin2bcd_seq #(
        .BIN_W (SCORE_W),
        .BCD_D (BCD_D)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (frame_start),
        .bin   (score),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bcd_ext   = (4*EXT_D)'(conv_bcd);
    assign conv_over = |bcd_ext[4*EXT_D-1:4*NUM_DIGITS];

    // Displayed digits change only on COMMIT, all at once; overflow saturates the display to all 9s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            overflow <= conv_over;
            disp     <= conv_over ? {NUM_DIGITS{4'h9}} : bcd_ext[4*NUM_DIGITS-1:0];
        end
    end

    // Fixed 8-entry digit view so a 3-bit index never leaves the array; unused slots read as zero.
    for (genvar k = 0; k < 8; k++) begin : g_dig
        if (k < NUM_DIGITS) begin : g_used
            assign dig_arr[k] = disp[4*k +: 4];
        end else begin : g_pad
            assign dig_arr[k] = 4'd0;
        end
    end

    // lz[d] = digits d..top are all zero (leading-zero run seen from the most significant end).
    always_comb begin
        logic zrun;
        lz   = '0;
        zrun = 1'b1;
        for (int k = 7; k >= 0; k--) begin
            zrun  = zrun && (dig_arr[k] == 4'd0);
            lz[k] = zrun;
        end
    end

    logic        s1_in_cell_d;
    logic [2:0]  s1_idx_d;
    logic [3:0]  s1_cx_d;
    logic [10:0] dxk;
    logic [10:0] dy;
    logic        in_rows;

    // 11-bit subtraction: a coordinate left of / above an origin goes negative instead of wrapping.
    assign dy      = {1'b0, V_Coord} - 11'(Y0);
    assign in_rows = !dy[10] && (dy < 11'(CELL_H));

    // Find which digit cell (if any) the column falls in; the inter-digit gap matches no cell.
    always_comb begin
        s1_in_cell_d = 1'b0;
        s1_idx_d     = 3'd0;
        s1_cx_d      = 4'd0;
        dxk          = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            dxk = {1'b0, H_Coord} - 11'(X0 + k * DIGIT_PITCH);
            if (!dxk[10] && (dxk < 11'(CELL_W))) begin
                s1_in_cell_d = in_rows;
                s1_idx_d     = 3'(NUM_DIGITS - 1 - k);
                s1_cx_d      = dxk[3:0];
            end
        end
    end

    logic       s1_in_cell;
    logic [2:0] s1_idx;
    logic [3:0] s1_cx;
    logic [3:0] s1_cy;

    // Stage 1: cell membership, digit index and cell-relative coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_in_cell <= 1'b0;
            s1_idx     <= 3'd0;
            s1_cx      <= 4'd0;
            s1_cy      <= 4'd0;
        end else begin
            s1_in_cell <= s1_in_cell_d;
            s1_idx     <= s1_idx_d;
            s1_cx      <= s1_cx_d;
            s1_cy      <= dy[3:0];
        end
    end

    logic seg_hit;
    logic blanked;

    assign seg_hit = |(seg_of_digit(dig_arr[s1_idx]) & seg_at(s1_cx, s1_cy));
    assign blanked = (BLANK_LZ != 0) && (s1_idx != 3'd0) && lz[s1_idx];

    // Stage 2: pixel is lit when it sits on a segment of a non-blanked digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            points_display <= 1'b0;
        end else begin
            points_display <= s1_in_cell && seg_hit && !blanked;
        end
    end

endmodule

// File: tb/tb_score_digits_renderer.sv
// tb/tb_score_digits_renderer.sv - scoreboard bench for score_digits_renderer (3-digit and 2-digit builds)
`timescale 1ns/1ps
module tb_score_digits_renderer;

    localparam int X0    = 10;
    localparam int Y0    = 15;
    localparam int PITCH = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] score = 8'd0;
    logic [9:0] h = 10'd0;
    logic [9:0] v = 10'd0;
    logic       pd_a, busy_a, ov_a;
    logic       pd_b, busy_b, ov_b;

    always #5 clk = ~clk;

    score_digits_renderer #(
        .SCORE_W(8), .NUM_DIGITS(3), .X0(X0), .Y0(Y0), .DIGIT_PITCH(PITCH), .BLANK_LZ(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .score(score), .frame_start(frame_start),
        .H_Coord(h), .V_Coord(v),
        .points_display(pd_a), .busy(busy_a), .overflow(ov_a)
    );

    score_digits_renderer #(
        .SCORE_W(8), .NUM_DIGITS(2), .X0(X0), .Y0(Y0), .DIGIT_PITCH(PITCH), .BLANK_LZ(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .score(score), .frame_start(frame_start),
        .H_Coord(h), .V_Coord(v),
        .points_display(pd_b), .busy(busy_b), .overflow(ov_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    string glyph [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
    int mdig_a [5];
    int mdig_b [5];
    int exp_ov_a = 0;
    int exp_ov_b = 0;

    function automatic bit on_seg(input byte s, input int cx, input int cy);
        case (s)
            "a":     return cy <= 3;
            "g":     return (cy >= 6) && (cy <= 8);
            "d":     return cy >= 11;
            "f":     return (cy <= 8) && (cx <= 2);
            "b":     return (cy <= 8) && (cx >= 10);
            "e":     return (cy >= 6) && (cx <= 2);
            "c":     return (cy >= 6) && (cx >= 10);
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_px(input int hh, input int vv, input bit sel_b);
        int  nd;
        int  dig [5];
        int  ox, cx, cy, val;
        bit  blank;
        nd = sel_b ? 2 : 3;
        for (int i = 0; i < 5; i++) dig[i] = sel_b ? mdig_b[i] : mdig_a[i];
        for (int d = 0; d < nd; d++) begin
            ox = X0 + (nd - 1 - d) * PITCH;
            cx = hh - ox;
            cy = vv - Y0;
            if (cx >= 0 && cx < 13 && cy >= 0 && cy < 15) begin
                blank = (d > 0);
                for (int j = d; j < nd; j++) if (dig[j] != 0) blank = 1'b0;
                if (blank) return 1'b0;
                val = dig[d];
                for (int i = 0; i < glyph[val].len(); i++)
                    if (on_seg(glyph[val][i], cx, cy)) return 1'b1;
                return 1'b0;
            end
        end
        return 1'b0;
    endfunction

    task automatic set_model(input int s);
        exp_ov_a = (s > 999) ? 1 : 0;
        exp_ov_b = (s > 99) ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            mdig_a[i] = (i < 3) ? (exp_ov_a != 0 ? 9 : (s / (10 ** i)) % 10) : 0;
            mdig_b[i] = (i < 2) ? (exp_ov_b != 0 ? 9 : (s / (10 ** i)) % 10) : 0;
        end
    endtask

    typedef struct {
        int    due;
        string tag;
        bit    exp_a;
        bit    exp_b;
    } px_exp_t;

    px_exp_t sb [$];
    int      cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pops every expectation that falls due this cycle and compares both renderers.
    always @(negedge clk) begin
        px_exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due != cyc) check_eq({e.tag, "_due"}, cyc, e.due);
            check_eq({e.tag, "_a"}, {31'd0, pd_a}, {31'd0, e.exp_a});
            check_eq({e.tag, "_b"}, {31'd0, pd_b}, {31'd0, e.exp_b});
        end
    end

    task automatic drive_px(input int hh, input int vv, input string tag);
        px_exp_t e;
        @(negedge clk);
        h = 10'(hh);
        v = 10'(vv);
        e.due = cyc + 2;
        e.tag = tag;
        e.exp_a = model_px(hh, vv, 1'b0);
        e.exp_b = model_px(hh, vv, 1'b1);
        sb.push_back(e);
    endtask

    task automatic drive_px_k(input int hh, input int vv, input string tag, input bit ea);
        px_exp_t e;
        @(negedge clk);
        h = 10'(hh);
        v = 10'(vv);
        e.due = cyc + 2;
        e.tag = tag;
        e.exp_a = ea;
        e.exp_b = model_px(hh, vv, 1'b1);
        sb.push_back(e);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic scan(input string tag);
        for (int vv = 14; vv <= 30; vv++)
            for (int hh = 0; hh <= 66; hh++)
                drive_px(hh, vv, tag);
        drain();
    endtask

    task automatic convert(input int s, input bit glitch, input string tag);
        int na, nb, guard;
        score = 8'(s);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        na = 0;
        nb = 0;
        guard = 0;
        while ((busy_a || busy_b) && guard < 100) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            guard++;
            if (glitch && guard == 3) begin
                score = 8'd77;
                frame_start = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            @(negedge clk);
        end
        frame_start = 1'b0;
        check_eq({tag, "_busy_len_a"}, na, 9);
        check_eq({tag, "_busy_len_b"}, nb, 9);
        set_model(s);
        check_eq({tag, "_ov_a"}, {31'd0, ov_a}, exp_ov_a);
        check_eq({tag, "_ov_b"}, {31'd0, ov_b}, exp_ov_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_model(0);
        #1;
        check_eq("rst_pd_a", {31'd0, pd_a}, 0);
        check_eq("rst_busy_a", {31'd0, busy_a}, 0);
        check_eq("rst_ov_a", {31'd0, ov_a}, 0);
        check_eq("rst_pd_b", {31'd0, pd_b}, 0);
        check_eq("rst_busy_b", {31'd0, busy_b}, 0);
        check_eq("rst_ov_b", {31'd0, ov_b}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // After reset: only the least significant "0" is lit.
        scan("scan_zero");
        drive_px_k(X0 + 2 * PITCH, Y0, "zero_ls_lit", 1'b1);
        drive_px_k(X0, Y0, "zero_ms_blank", 1'b0);
        drain();
        check_eq("idle_busy_a", {31'd0, busy_a}, 0);

        // 15 -> "015" with the leading zero blanked.
        convert(15, 1'b0, "cv15");
        scan("scan_15");
        drive_px_k(X0 + 2 * PITCH + 1, Y0 + 5, "d5_f_lit", 1'b1);
        drive_px_k(X0 + 2 * PITCH + 11, Y0 + 5, "d5_b_dark", 1'b0);
        drive_px_k(X0 + 2 * PITCH + 1, Y0 + 9, "d5_e_dark", 1'b0);
        drive_px_k(X0 + 2 * PITCH + 11, Y0 + 9, "d5_c_lit", 1'b1);
        drive_px_k(X0 + PITCH + 1, Y0 + 2, "d1_left_dark", 1'b0);
        drive_px_k(X0 + PITCH + 11, Y0 + 2, "d1_right_lit", 1'b1);
        drain();

        // 255 overflows the 2-digit build only; 42 clears it again.
        convert(255, 1'b0, "cv255");
        scan("scan_255");
        convert(42, 1'b0, "cv42");
        scan("scan_42");

        // A frame_start during conversion is ignored.
        convert(123, 1'b1, "cv123_glitch");
        scan("scan_123");

        // Reset in the middle of SHIFT.
        drive_px_k(X0 + 2 * PITCH + 1, Y0, "pre_rst_px", 1'b1);
        drain();
        score = 8'd200;
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_rst_pd_a", {31'd0, pd_a}, 1);
        check_eq("pre_rst_busy_a", {31'd0, busy_a}, 1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pd_a", {31'd0, pd_a}, 0);
        check_eq("midrst_busy_a", {31'd0, busy_a}, 0);
        check_eq("midrst_busy_b", {31'd0, busy_b}, 0);
        check_eq("midrst_ov_b", {31'd0, ov_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        set_model(0);
        scan("scan_after_rst");
        convert(200, 1'b0, "cv200");
        scan("scan_200");

        // Right edge of the LS cell, and coordinates before the origin.
        drive_px_k(X0 + 2 * PITCH + 12, Y0, "edge_cx12_0", 1'b1);
        drive_px_k(X0 + 2 * PITCH + 12, Y0, "edge_cx12_1", 1'b1);
        drive_px_k(X0 + 2 * PITCH + 13, Y0, "edge_cx13_0", 1'b0);
        drive_px_k(X0 + 2 * PITCH + 13, Y0, "edge_cx13_1", 1'b0);
        drive_px_k(X0 + 2 * PITCH + 12, Y0, "edge_cx12_2", 1'b1);
        drive_px_k(X0 - 5, Y0, "left_of_x0", 1'b0);
        drive_px_k(X0 + 2 * PITCH, Y0 - 5, "above_y0", 1'b0);
        drive_px_k(1023, 1023, "far_corner", 1'b0);
        drain();

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
